// File: rtl/matrix_pattern_streamer.sv
// LED-matrix test-pattern source (row fill / column scroll / checker), OVERRUN_CNT_EN adds a dropped-tick counter.
// Frame is visible 1 cycle after its tick; ticks arriving while a frame waits unaccepted are dropped.
module matrix_pattern_streamer #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int DIV_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [1:0]             mode,
   input  logic [DIV_W-1:0]       step_div,
   input  logic                   frame_ready,
   output logic                   frame_valid,
   output logic [ROWS*COLS-1:0]   frame_data,
`ifdef OVERRUN_CNT_EN
   output logic [7:0]             overrun_count,
`endif
   output logic [7:0]             frame_count
);

   localparam int PW = $clog2(ROWS + COLS);
   localparam logic [PW-1:0] PH_ROW_LAST = PW'(ROWS);
   localparam logic [PW-1:0] PH_COL_LAST = PW'(COLS - 1);

   typedef enum logic {IDLE, PEND} state_e;
   typedef enum logic [1:0] {M_ROW = 2'd0, M_COL = 2'd1, M_CHK = 2'd2, M_HOLD = 2'd3} mode_e;

   state_e                 state_q, state_d;
   mode_e                  mode_q, mode_d, mode_in;
   logic [PW-1:0]          phase_q, phase_d, emit_ph, ph_next;
   logic [DIV_W-1:0]       div_q, div_d;
   logic [ROWS*COLS-1:0]   data_q, data_d, pattern;
   logic [7:0]             cnt_q, cnt_d;
   logic                   tick, accept, step;

   assign mode_in     = mode_e'(mode);
   assign tick        = en && (div_q >= step_div);
   assign accept      = (state_q == PEND) && frame_ready;
   assign step        = tick && (mode_in != M_HOLD) && ((state_q == IDLE) || frame_ready);
   // A mode change restarts the new animation at phase 0.
   assign emit_ph     = (mode_in != mode_q) ? '0 : phase_q;

   assign frame_valid = (state_q == PEND);
   assign frame_data  = data_q;
   assign frame_count = cnt_q;

   always_comb begin
      div_d = div_q + DIV_W'(1);
      if (!en || tick) div_d = '0;
   end

   always_comb begin
      int ph;
      pattern = '0;
      ph      = int'(emit_ph);
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            case (mode_in)
               M_ROW:   pattern[r*COLS+c] = (r + ph >= ROWS);
               M_COL:   pattern[r*COLS+c] = (c + ph == COLS - 1);
               M_CHK:   pattern[r*COLS+c] = ((r + c + ph) % 2 == 0);
               default: pattern[r*COLS+c] = 1'b0;
            endcase
         end
      end
   end

   always_comb begin
      ph_next = phase_q;
      case (mode_in)
         M_ROW:   ph_next = (emit_ph >= PH_ROW_LAST) ? '0 : emit_ph + PW'(1);
         M_COL:   ph_next = (emit_ph >= PH_COL_LAST) ? '0 : emit_ph + PW'(1);
         M_CHK:   ph_next = (emit_ph != '0) ? '0 : PW'(1);
         default: ph_next = phase_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      phase_d = phase_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (accept) cnt_d = cnt_q + 8'd1;
      // phase_q holds the phase of the next frame to emit
      if (step) begin
         data_d  = pattern;
         mode_d  = mode_in;
         phase_d = ph_next;
      end
      case (state_q)
         IDLE:    if (step) state_d = PEND;
         PEND:    if (accept && !step) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         mode_q  <= M_ROW;
         phase_q <= '0;
         div_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         phase_q <= phase_d;
         div_q   <= div_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef OVERRUN_CNT_EN
   logic       drop;
   logic [7:0] ovr_q, ovr_d;

   assign drop          = tick && (mode_in != M_HOLD) && (state_q == PEND) && !frame_ready;
   assign overrun_count = ovr_q;

   always_comb begin
      ovr_d = ovr_q;
      if (drop && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ovr_q <= '0;
      else      ovr_q <= ovr_d;
   end
`endif

endmodule
